mode_display_ctrl: RTL and testbench

Parametrised successor of the cycle-computer display controller.
- Rotates through NUM_MODES display modes on the mode button and drives one-hot mode and indicator lines.
- Blinks the non-active indicators on over-speed and gates the trip counters when stopped.
- Schedules display refreshes through a start/valid handshake with the binary-to-ASCII converter. The handshake has pending-request queueing and timeout recovery.
- Issues a trip-clear pulse on a long mode-button press.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/refresh_sched.sv | 84 ++++++++
 rtl/mode_display_ctrl.sv | 138 +++++++++++++
 tb/tb_mode_display_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the cycle-computer display controller.
// Holds the refresh-state enum, a clog2 helper and the default segment masks.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    LATCH
  } rfsh_state_e;

  localparam logic [7:0] DEF_POINT_MASK = 8'b0000_0011;
  localparam logic [7:0] DEF_COLON_MASK = 8'b0000_0100;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/refresh_sched.sv
// Display refresh scheduler: start/valid handshake with the converter,
// one-deep request queue and timeout recovery with a sticky error flag.
module refresh_sched
  import disp_pkg::*;
#(
  parameter int CONV_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  input  logic conv_valid_i,
  output logic conv_start_o,
  output logic latch_en_o,
  output logic conv_err_o
);

  localparam int TW = clog2(CONV_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(CONV_TIMEOUT);

  rfsh_state_e state_q, state_d;
  logic          req_q;
  logic          pending_q, pending_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [TW-1:0] tcnt_inc;

  assign tcnt_inc = tcnt_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_q) state_d = REQ;
      end
      REQ: begin
        tcnt_d  = '0;
        state_d = WAIT;
        if (req_q) pending_d = 1'b1;
      end
      WAIT: begin
        if (req_q) pending_d = 1'b1;
        if (conv_valid_i) begin
          state_d = LATCH;
        end else if (tcnt_inc == TMAX) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          pending_d = 1'b0;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      LATCH: begin
        // a request landing here either starts the next round or stays queued
        state_d   = (pending_q | req_q) ? REQ : IDLE;
        pending_d = pending_q & req_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_i;
      pending_q <= pending_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign conv_start_o = (state_q == REQ);
  assign latch_en_o   = (state_q == LATCH);
  assign conv_err_o   = err_q;

endmodule

// File: rtl/mode_display_ctrl.sv
// Cycle-computer display controller: mode rotation, indicator blink,
// long-press trip clear, segment control and refresh scheduling.
module mode_display_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_MODES       = 4,
  parameter int SPEED_WIDTH     = 7,
  parameter int OVERSPEED_LIMIT = 65,
  parameter int STOP_LIMIT      = 6,
  parameter logic [NUM_MODES-1:0] POINT_MASK =
    DEF_POINT_MASK[NUM_MODES-1:0],
  parameter logic [NUM_MODES-1:0] COLON_MASK =
    DEF_COLON_MASK[NUM_MODES-1:0],
  parameter int LONG_PRESS_SEC  = 2,
  parameter int CONV_TIMEOUT    = 15,
  localparam int MODE_W = clog2(NUM_MODES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   mode_hold,
  input  logic                   half_sec_pulse,
  input  logic                   sec_pulse,
  input  logic [SPEED_WIDTH-1:0] speed,
  input  logic                   speed_valid,
  input  logic                   conv_valid,
  output logic [MODE_W-1:0]      mode_sel,
  output logic [NUM_MODES-1:0]   mode_onehot,
  output logic [NUM_MODES-1:0]   mode_ind,
  output logic                   conv_start,
  output logic                   latch_en,
  output logic                   point,
  output logic                   col,
  output logic                   en_motion,
  output logic                   trip_clear,
  output logic                   conv_err
);

  localparam int HW = clog2(LONG_PRESS_SEC + 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_SEC);
  localparam logic [SPEED_WIDTH-1:0] OVR = SPEED_WIDTH'(OVERSPEED_LIMIT);
  localparam logic [SPEED_WIDTH-1:0] STP = SPEED_WIDTH'(STOP_LIMIT);
  localparam logic [MODE_W-1:0] LAST = MODE_W'(NUM_MODES - 1);

  logic [MODE_W-1:0]      sel_q, sel_d;
  logic [NUM_MODES-1:0]   oh_q, oh_d;
  logic [NUM_MODES-1:0]   ind_q, ind_d;
  logic [SPEED_WIDTH-1:0] speed_q;
  logic                   mode_q;
  logic                   blink_q;
  logic                   en_q;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   trip_q, trip_d;
  logic                   point_q, point_d;
  logic                   col_q, col_d;
  logic                   high_speed;
  logic                   seg_upd;

  assign high_speed = speed_q > OVR;
  assign seg_upd    = sec_pulse | mode_q;

  always_comb begin
    sel_d = sel_q;
    if (mode) sel_d = (sel_q == LAST) ? '0 : sel_q + MODE_W'(1);
    oh_d  = NUM_MODES'(1) << sel_d;
    ind_d = oh_q | ((high_speed & blink_q) ? ~oh_q : '0);
  end

  // saturates at the threshold so a held button clears the trip only once
  always_comb begin
    hold_d = hold_q;
    trip_d = 1'b0;
    if (!mode_hold) begin
      hold_d = '0;
    end else if (sec_pulse && hold_q != HMAX) begin
      hold_d = hold_q + HW'(1);
      trip_d = (hold_d == HMAX);
    end
  end

  always_comb begin
    point_d = point_q;
    col_d   = col_q;
    if (seg_upd) begin
      point_d = POINT_MASK[sel_q];
      col_d   = COLON_MASK[sel_q] ? ~col_q : 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q   <= '0;
      oh_q    <= NUM_MODES'(1);
      ind_q   <= NUM_MODES'(1);
      speed_q <= '0;
      mode_q  <= 1'b0;
      blink_q <= 1'b0;
      en_q    <= 1'b0;
      hold_q  <= '0;
      trip_q  <= 1'b0;
      point_q <= POINT_MASK[0];
      col_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      oh_q    <= oh_d;
      ind_q   <= ind_d;
      if (speed_valid) speed_q <= speed;
      mode_q  <= mode;
      if (half_sec_pulse) blink_q <= ~blink_q;
      en_q    <= speed_q >= STP;
      hold_q  <= hold_d;
      trip_q  <= trip_d;
      point_q <= point_d;
      col_q   <= col_d;
    end
  end

  refresh_sched #(
    .CONV_TIMEOUT(CONV_TIMEOUT)
  ) u_sched (
    .clock       (clock),
    .reset       (reset),
    .req_i       (seg_upd),
    .conv_valid_i(conv_valid),
    .conv_start_o(conv_start),
    .latch_en_o  (latch_en),
    .conv_err_o  (conv_err)
  );

  assign mode_sel    = sel_q;
  assign mode_onehot = oh_q;
  assign mode_ind    = ind_q;
  assign point       = point_q;
  assign col         = col_q;
  assign en_motion   = en_q;
  assign trip_clear  = trip_q;

endmodule

// File: tb/tb_mode_display_ctrl.sv
// Bench for mode_display_ctrl: table of steady-state vectors plus
// handshake sequences checked against a queue of expected event cycles.
module tb_mode_display_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       mode_hold = 1'b0;
  logic       half_sec_pulse = 1'b0;
  logic       sec_pulse = 1'b0;
  logic [6:0] speed = '0;
  logic       speed_valid = 1'b0;
  logic       conv_valid = 1'b0;
  logic [1:0] mode_sel;
  logic [3:0] mode_onehot;
  logic [3:0] mode_ind;
  logic       conv_start;
  logic       latch_en;
  logic       point;
  logic       col;
  logic       en_motion;
  logic       trip_clear;
  logic       conv_err;

  mode_display_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .mode_hold     (mode_hold),
    .half_sec_pulse(half_sec_pulse),
    .sec_pulse     (sec_pulse),
    .speed         (speed),
    .speed_valid   (speed_valid),
    .conv_valid    (conv_valid),
    .mode_sel      (mode_sel),
    .mode_onehot   (mode_onehot),
    .mode_ind      (mode_ind),
    .conv_start    (conv_start),
    .latch_en      (latch_en),
    .point         (point),
    .col           (col),
    .en_motion     (en_motion),
    .trip_clear    (trip_clear),
    .conv_err      (conv_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       md;
    logic       sec;
    logic       half;
    logic       sv;
    logic [6:0] spd;
    logic [1:0] sel;
    logic [3:0] oh;
    logic [3:0] ind;
    logic       en;
    logic       pt;
    logic       cl;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   tc_cnt = 0;
  bit   mon_en = 1'b0;
  int   exp_start[$];
  int   exp_latch[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    int e;
    @(posedge clock);
    #1;
    cyc++;
    if (trip_clear) tc_cnt++;
    if (mon_en && conv_start) begin
      if (exp_start.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL conv_start: got pulse at %0d expected none", cyc);
      end else begin
        e = exp_start.pop_front();
        chk("conv_start_cyc", 32'(cyc), 32'(e));
      end
    end
    if (mon_en && latch_en) begin
      if (exp_latch.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL latch_en: got pulse at %0d expected none", cyc);
      end else begin
        e = exp_latch.pop_front();
        chk("latch_en_cyc", 32'(cyc), 32'(e));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic at(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_sec();
    sec_pulse = 1'b1;
    tick();
    sec_pulse = 1'b0;
  endtask

  task automatic pulse_cv();
    conv_valid = 1'b1;
    tick();
    conv_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(mode_sel), 0);
    chk({tag, "_oh"}, 32'(mode_onehot), 1);
    chk({tag, "_ind"}, 32'(mode_ind), 1);
    chk({tag, "_start"}, 32'(conv_start), 0);
    chk({tag, "_latch"}, 32'(latch_en), 0);
    chk({tag, "_point"}, 32'(point), 1);
    chk({tag, "_col"}, 32'(col), 0);
    chk({tag, "_en"}, 32'(en_motion), 0);
    chk({tag, "_trip"}, 32'(trip_clear), 0);
    chk({tag, "_err"}, 32'(conv_err), 0);
  endtask

  function automatic vec_t mk(bit md, bit sec, bit half, bit sv,
                              int spd, int sel, int oh, int ind,
                              bit en, bit pt, bit cl);
    vec_t v;
    v.md   = md;
    v.sec  = sec;
    v.half = half;
    v.sv   = sv;
    v.spd  = 7'(spd);
    v.sel  = 2'(sel);
    v.oh   = 4'(oh);
    v.ind  = 4'(ind);
    v.en   = en;
    v.pt   = pt;
    v.cl   = cl;
    return v;
  endfunction

  initial begin
    int c;
    int tc0;
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'b0010, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 4'b0100, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 4'b1000, 4'b1000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'b0010, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 4'b0100, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 70, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 4'b0100, 4'b1111, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 4'b0100, 4'b1111, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 60, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 66, 2, 4'b0100, 4'b1111, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 65, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 5, 2, 4'b0100, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 6, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, 4'b0100, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, 4'b0100, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 4'b1000, 4'b1000, 1, 0, 0));

    #1 reset = 1'b0;
    #1 chk_reset("por");
    idle(2);
    reset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      mode           = tbl[i].md;
      sec_pulse      = tbl[i].sec;
      half_sec_pulse = tbl[i].half;
      speed_valid    = tbl[i].sv;
      speed          = tbl[i].spd;
      tick();
      mode           = 1'b0;
      sec_pulse      = 1'b0;
      half_sec_pulse = 1'b0;
      speed_valid    = 1'b0;
      tick();
      chk($sformatf("v%0d_sel", i), 32'(mode_sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d_oh", i), 32'(mode_onehot), 32'(tbl[i].oh));
      chk($sformatf("v%0d_ind", i), 32'(mode_ind), 32'(tbl[i].ind));
      chk($sformatf("v%0d_en", i), 32'(en_motion), 32'(tbl[i].en));
      chk($sformatf("v%0d_pt", i), 32'(point), 32'(tbl[i].pt));
      chk($sformatf("v%0d_col", i), 32'(col), 32'(tbl[i].cl));
    end

    speed = 7'd5;
    speed_valid = 1'b1;
    tick();
    speed_valid = 1'b0;
    chk("en_stop_lat1", 32'(en_motion), 1);
    tick();
    chk("en_stop_lat2", 32'(en_motion), 0);
    speed = 7'd6;
    speed_valid = 1'b1;
    tick();
    speed_valid = 1'b0;
    chk("en_go_lat1", 32'(en_motion), 0);
    tick();
    chk("en_go_lat2", 32'(en_motion), 1);

    do_reset();
    idle(2);
    chk("err_clear", 32'(conv_err), 0);
    mon_en = 1'b1;

    c = cyc;
    exp_start.push_back(c + 2);
    pulse_sec();
    at(c + 4);
    exp_start.push_back(c + 8);
    pulse_sec();
    at(c + 6);
    exp_latch.push_back(c + 7);
    pulse_cv();
    at(c + 10);
    exp_latch.push_back(c + 11);
    pulse_cv();
    at(c + 14);
    chk("hs_start_left", 32'(exp_start.size()), 0);
    chk("hs_latch_left", 32'(exp_latch.size()), 0);

    c = cyc;
    exp_start.push_back(c + 2);
    pulse_sec();
    at(c + 4);
    pulse_sec();
    at(c + 6);
    pulse_sec();
    at(c + 8);
    exp_latch.push_back(c + 9);
    exp_start.push_back(c + 10);
    pulse_cv();
    at(c + 12);
    exp_latch.push_back(c + 13);
    pulse_cv();
    at(c + 18);
    chk("merge_start_left", 32'(exp_start.size()), 0);
    chk("merge_latch_left", 32'(exp_latch.size()), 0);
    chk("merge_err", 32'(conv_err), 0);

    c = cyc;
    exp_start.push_back(c + 2);
    pulse_sec();
    at(c + 17);
    chk("to_err_before", 32'(conv_err), 0);
    tick();
    chk("to_err_set", 32'(conv_err), 1);
    at(c + 20);
    pulse_cv();
    at(c + 22);
    exp_start.push_back(c + 24);
    pulse_sec();
    at(c + 26);
    exp_latch.push_back(c + 27);
    pulse_cv();
    at(c + 30);
    chk("to_err_sticky", 32'(conv_err), 1);
    chk("to_start_left", 32'(exp_start.size()), 0);
    chk("to_latch_left", 32'(exp_latch.size()), 0);

    mon_en = 1'b0;
    mode_hold = 1'b1;
    tc0 = tc_cnt;
    pulse_sec();
    chk("trip_1st", 32'(trip_clear), 0);
    idle(3);
    pulse_sec();
    chk("trip_2nd", 32'(trip_clear), 1);
    tick();
    chk("trip_pulse_end", 32'(trip_clear), 0);
    idle(3);
    pulse_sec();
    idle(3);
    chk("trip_count", 32'(tc_cnt - tc0), 1);
    mode_hold = 1'b0;
    idle(50);

    mon_en = 1'b1;
    c = cyc;
    exp_start.push_back(c + 2);
    pulse_sec();
    at(c + 5);
    reset = 1'b0;
    #1;
    chk_reset("midwait");
    conv_valid = 1'b1;
    idle(2);
    conv_valid = 1'b0;
    reset = 1'b1;
    idle(4);
    chk("mw_latch", 32'(latch_en), 0);
    chk("mw_start_left", 32'(exp_start.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
